// File: rtl/dual_port_seq_bank.sv
// Two-port banked word memory with per-byte write strobes and 1-cycle read latency.
// Same-bank collisions are resolved by a 1-bit round-robin pointer; the loser retries next cycle.
module dual_port_seq_bank #(
    parameter int DATA_WIDTH       = 32,
    parameter int BYTE_ADDR_WIDTH  = 8,
    parameter int BANKS_ADDR_WIDTH = 2,
    localparam int AW = BYTE_ADDR_WIDTH + BANKS_ADDR_WIDTH,
    localparam int SW = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  a_valid,
    output logic                  a_ready,
    input  logic                  a_wen,
    input  logic [AW-1:0]         a_addr,
    input  logic [DATA_WIDTH-1:0] a_din,
    input  logic [SW-1:0]         a_strb,
    output logic                  a_rvalid,
    output logic [DATA_WIDTH-1:0] a_rdata,
    input  logic                  b_valid,
    output logic                  b_ready,
    input  logic                  b_wen,
    input  logic [AW-1:0]         b_addr,
    input  logic [DATA_WIDTH-1:0] b_din,
    input  logic [SW-1:0]         b_strb,
    output logic                  b_rvalid,
    output logic [DATA_WIDTH-1:0] b_rdata
);

    localparam int NUM_SB = 2 ** BANKS_ADDR_WIDTH;
    localparam int DEPTH  = 2 ** BYTE_ADDR_WIDTH;

    logic [DATA_WIDTH-1:0]       mem_r [NUM_SB][DEPTH];

    logic [BANKS_ADDR_WIDTH-1:0] a_bank_s;
    logic [BANKS_ADDR_WIDTH-1:0] b_bank_s;
    logic [BYTE_ADDR_WIDTH-1:0]  a_word_s;
    logic [BYTE_ADDR_WIDTH-1:0]  b_word_s;
    logic                        same_bank_s;
    logic                        conflict_s;
    logic                        a_ready_s;
    logic                        b_ready_s;
    logic                        a_acc_s;
    logic                        b_acc_s;

    logic                        prio_r;
    logic                        a_rvalid_r;
    logic                        b_rvalid_r;
    logic [DATA_WIDTH-1:0]       a_rdata_r;
    logic [DATA_WIDTH-1:0]       b_rdata_r;

    // Address split, arbitration and acceptance; ready never looks at its own port's valid.
    always_comb begin
        a_bank_s    = a_addr[AW-1 -: BANKS_ADDR_WIDTH];
        b_bank_s    = b_addr[AW-1 -: BANKS_ADDR_WIDTH];
        a_word_s    = a_addr[BYTE_ADDR_WIDTH-1:0];
        b_word_s    = b_addr[BYTE_ADDR_WIDTH-1:0];
        same_bank_s = (a_bank_s == b_bank_s);
        conflict_s  = a_valid && b_valid && same_bank_s;
        a_ready_s   = 1'b0;
        b_ready_s   = 1'b0;
        if (rst_n) begin
            a_ready_s = !(b_valid && same_bank_s && prio_r);
            b_ready_s = !(a_valid && same_bank_s && !prio_r);
        end else begin
            a_ready_s = 1'b0;
            b_ready_s = 1'b0;
        end
        a_acc_s = a_valid && a_ready_s;
        b_acc_s = b_valid && b_ready_s;
    end

    // Byte-masked writes; the arbiter guarantees the two ports never hit the same bank.
    always_ff @(posedge clk) begin
        for (int i = 0; i < SW; i++) begin
            if (a_acc_s && a_wen && a_strb[i]) begin
                mem_r[a_bank_s][a_word_s][i*8 +: 8] <= a_din[i*8 +: 8];
            end
            if (b_acc_s && b_wen && b_strb[i]) begin
                mem_r[b_bank_s][b_word_s][i*8 +: 8] <= b_din[i*8 +: 8];
            end
        end
    end

    // Round-robin pointer and read response registers; memory contents survive reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prio_r     <= 1'b0;
            a_rvalid_r <= 1'b0;
            b_rvalid_r <= 1'b0;
            a_rdata_r  <= {DATA_WIDTH{1'b0}};
            b_rdata_r  <= {DATA_WIDTH{1'b0}};
        end else begin
            prio_r     <= conflict_s ? ~prio_r : prio_r;
            a_rvalid_r <= a_acc_s && !a_wen;
            b_rvalid_r <= b_acc_s && !b_wen;
            if (a_acc_s && !a_wen) begin
                a_rdata_r <= mem_r[a_bank_s][a_word_s];
            end
            if (b_acc_s && !b_wen) begin
                b_rdata_r <= mem_r[b_bank_s][b_word_s];
            end
        end
    end

    assign a_ready  = a_ready_s;
    assign b_ready  = b_ready_s;
    assign a_rvalid = a_rvalid_r;
    assign b_rvalid = b_rvalid_r;
    assign a_rdata  = a_rdata_r;
    assign b_rdata  = b_rdata_r;

endmodule

// File: tb/tb_dual_port_seq_bank.sv
// Directed scenarios plus randomized two-port traffic checked against a flat reference memory.
module tb_dual_port_seq_bank;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_valid, a_ready, a_wen, a_rvalid;
    logic [9:0]  a_addr;
    logic [31:0] a_din, a_rdata;
    logic [3:0]  a_strb;
    logic        b_valid, b_ready, b_wen, b_rvalid;
    logic [9:0]  b_addr;
    logic [31:0] b_din, b_rdata;
    logic [3:0]  b_strb;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] mdl [1024];

    dual_port_seq_bank dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_ready(a_ready), .a_wen(a_wen), .a_addr(a_addr),
        .a_din(a_din), .a_strb(a_strb), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_valid(b_valid), .b_ready(b_ready), .b_wen(b_wen), .b_addr(b_addr),
        .b_din(b_din), .b_strb(b_strb), .b_rvalid(b_rvalid), .b_rdata(b_rdata)
    );

    always #5 clk = ~clk;

    task automatic set_a(input logic v, input logic w, input logic [9:0] ad,
                         input logic [31:0] d, input logic [3:0] s);
        a_valid = v; a_wen = w; a_addr = ad; a_din = d; a_strb = s;
    endtask

    task automatic set_b(input logic v, input logic w, input logic [9:0] ad,
                         input logic [31:0] d, input logic [3:0] s);
        b_valid = v; b_wen = w; b_addr = ad; b_din = d; b_strb = s;
    endtask

    task automatic idle();
        set_a(1'b0, 1'b0, 10'h000, 32'h0, 4'h0);
        set_b(1'b0, 1'b0, 10'h000, 32'h0, 4'h0);
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        set_a(1'b1, 1'b0, 10'h021, 32'h0, 4'h0);
        set_b(1'b1, 1'b0, 10'h321, 32'h0, 4'h0);
        #1;
        n_cmp++; if (a_ready !== 1'b0) begin n_bad++; $display("FAIL rst_a_ready got %b want 0", a_ready); end
        n_cmp++; if (b_ready !== 1'b0) begin n_bad++; $display("FAIL rst_b_ready got %b want 0", b_ready); end
        @(posedge clk); #1;
        n_cmp++; if (a_rvalid !== 1'b0) begin n_bad++; $display("FAIL rst_a_rvalid got %b want 0", a_rvalid); end
        n_cmp++; if (b_rvalid !== 1'b0) begin n_bad++; $display("FAIL rst_b_rvalid got %b want 0", b_rvalid); end
        n_cmp++; if (a_rdata !== 32'h0) begin n_bad++; $display("FAIL rst_a_rdata got %h want 0", a_rdata); end
        n_cmp++; if (b_rdata !== 32'h0) begin n_bad++; $display("FAIL rst_b_rdata got %h want 0", b_rdata); end
        @(negedge clk);
        rst_n = 1'b1;
        idle();
    endtask

    task automatic test_write_read();
        @(negedge clk);
        set_a(1'b1, 1'b1, 10'h005, 32'hDEADBEEF, 4'hF);
        #1;
        n_cmp++; if (a_ready !== 1'b1) begin n_bad++; $display("FAIL wr_a_ready got %b want 1", a_ready); end
        @(posedge clk);
        @(negedge clk);
        idle();
        set_b(1'b1, 1'b0, 10'h005, 32'h0, 4'h0);
        #1;
        n_cmp++; if (a_rvalid !== 1'b0) begin n_bad++; $display("FAIL wr_no_rvalid got %b want 0", a_rvalid); end
        n_cmp++; if (b_ready !== 1'b1) begin n_bad++; $display("FAIL rd_b_ready got %b want 1", b_ready); end
        @(posedge clk);
        @(negedge clk);
        idle();
        #1;
        n_cmp++; if (b_rvalid !== 1'b1) begin n_bad++; $display("FAIL raw_b_rvalid got %b want 1", b_rvalid); end
        n_cmp++; if (b_rdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL raw_b_rdata got %h want deadbeef", b_rdata); end
        @(posedge clk); #1;
        n_cmp++; if (b_rvalid !== 1'b0) begin n_bad++; $display("FAIL pulse_b_rvalid got %b want 0", b_rvalid); end
        n_cmp++; if (b_rdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL hold_b_rdata got %h want deadbeef", b_rdata); end
    endtask

    task automatic test_strobe();
        @(negedge clk); set_a(1'b1, 1'b1, 10'h010, 32'h11223344, 4'hF);
        @(negedge clk); set_a(1'b1, 1'b1, 10'h010, 32'h0000AA00, 4'h2);
        @(negedge clk); set_a(1'b1, 1'b0, 10'h010, 32'h0, 4'h0);
        @(negedge clk); set_a(1'b1, 1'b1, 10'h010, 32'hFFFFFFFF, 4'h0);
        #1;
        n_cmp++; if (a_rvalid !== 1'b1 || a_rdata !== 32'h1122AA44) begin
            n_bad++; $display("FAIL strb_merge got %b/%h want 1/1122aa44", a_rvalid, a_rdata); end
        @(negedge clk); set_a(1'b1, 1'b0, 10'h010, 32'h0, 4'h0);
        #1;
        n_cmp++; if (a_rvalid !== 1'b0) begin n_bad++; $display("FAIL strb0_rvalid got %b want 0", a_rvalid); end
        @(negedge clk); idle();
        #1;
        n_cmp++; if (a_rdata !== 32'h1122AA44) begin n_bad++; $display("FAIL strb0_noop got %h want 1122aa44", a_rdata); end
    endtask

    task automatic test_conflict();
        @(negedge clk); set_a(1'b1, 1'b1, 10'h100, 32'hA1000001, 4'hF);
        @(negedge clk); set_a(1'b1, 1'b1, 10'h1FF, 32'hB1FF0002, 4'hF);
        @(negedge clk); idle(); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        set_a(1'b1, 1'b0, 10'h100, 32'h0, 4'h0);
        set_b(1'b1, 1'b0, 10'h1FF, 32'h0, 4'h0);
        #1;
        n_cmp++; if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
            n_bad++; $display("FAIL cf_c0_ready got a=%b b=%b want a=1 b=0", a_ready, b_ready); end
        @(negedge clk);
        #1;
        n_cmp++; if (a_ready !== 1'b0 || b_ready !== 1'b1) begin
            n_bad++; $display("FAIL cf_c1_ready got a=%b b=%b want a=0 b=1", a_ready, b_ready); end
        n_cmp++; if (a_rvalid !== 1'b1 || a_rdata !== 32'hA1000001) begin
            n_bad++; $display("FAIL cf_c1_a_rd got %b/%h want 1/a1000001", a_rvalid, a_rdata); end
        @(negedge clk);
        #1;
        n_cmp++; if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
            n_bad++; $display("FAIL cf_c2_ready got a=%b b=%b want a=1 b=0", a_ready, b_ready); end
        n_cmp++; if (b_rvalid !== 1'b1 || b_rdata !== 32'hB1FF0002 || a_rvalid !== 1'b0) begin
            n_bad++; $display("FAIL cf_c2_b_rd got %b/%h a_rv=%b want 1/b1ff0002 a_rv=0", b_rvalid, b_rdata, a_rvalid); end
        @(negedge clk);
        set_a(1'b0, 1'b0, 10'h000, 32'h0, 4'h0);
        #1;
        n_cmp++; if (b_ready !== 1'b1) begin n_bad++; $display("FAIL cf_c3_b_ready got %b want 1", b_ready); end
        n_cmp++; if (a_rvalid !== 1'b1 || a_rdata !== 32'hA1000001) begin
            n_bad++; $display("FAIL cf_c3_a_rd got %b/%h want 1/a1000001", a_rvalid, a_rdata); end
        @(negedge clk); idle();
        #1;
        n_cmp++; if (b_rvalid !== 1'b1 || b_rdata !== 32'hB1FF0002) begin
            n_bad++; $display("FAIL cf_c4_b_rd got %b/%h want 1/b1ff0002", b_rvalid, b_rdata); end
    endtask

    task automatic test_diff_banks();
        @(negedge clk); set_a(1'b1, 1'b1, 10'h000, 32'h0BADF00D, 4'hF);
        @(negedge clk);
        set_a(1'b1, 1'b0, 10'h000, 32'h0, 4'h0);
        set_b(1'b1, 1'b1, 10'h300, 32'h33334444, 4'hF);
        #1;
        n_cmp++; if (a_ready !== 1'b1 || b_ready !== 1'b1) begin
            n_bad++; $display("FAIL db_ready got a=%b b=%b want both 1", a_ready, b_ready); end
        @(negedge clk);
        set_a(1'b1, 1'b0, 10'h0AA, 32'h0, 4'h0);
        set_b(1'b1, 1'b0, 10'h0BB, 32'h0, 4'h0);
        #1;
        n_cmp++; if (a_rvalid !== 1'b1 || a_rdata !== 32'h0BADF00D || b_rvalid !== 1'b0) begin
            n_bad++; $display("FAIL db_rd got %b/%h b_rv=%b want 1/0badf00d b_rv=0", a_rvalid, a_rdata, b_rvalid); end
        n_cmp++; if (a_ready !== 1'b0 || b_ready !== 1'b1) begin
            n_bad++; $display("FAIL db_prio_held got a=%b b=%b want a=0 b=1", a_ready, b_ready); end
        @(negedge clk);
        set_b(1'b1, 1'b0, 10'h300, 32'h0, 4'h0);
        #1;
        n_cmp++; if (a_ready !== 1'b1 || b_ready !== 1'b1) begin
            n_bad++; $display("FAIL db_retry got a=%b b=%b want both 1", a_ready, b_ready); end
        @(negedge clk); idle();
        #1;
        n_cmp++; if (b_rvalid !== 1'b1 || b_rdata !== 32'h33334444) begin
            n_bad++; $display("FAIL db_b_wr got %b/%h want 1/33334444", b_rvalid, b_rdata); end
    endtask

    task automatic test_reset_read();
        @(negedge clk); set_a(1'b1, 1'b1, 10'h022, 32'hC0FFEE01, 4'hF);
        @(negedge clk); set_a(1'b1, 1'b0, 10'h022, 32'h0, 4'h0);
        @(negedge clk);
        rst_n = 1'b0;
        set_a(1'b1, 1'b1, 10'h022, 32'h99999999, 4'hF);
        #1;
        n_cmp++; if (a_ready !== 1'b0) begin n_bad++; $display("FAIL rr_a_ready got %b want 0", a_ready); end
        @(posedge clk); #1;
        n_cmp++; if (a_rvalid !== 1'b0 || a_rdata !== 32'h0) begin
            n_bad++; $display("FAIL rr_suppress got %b/%h want 0/0", a_rvalid, a_rdata); end
        @(negedge clk);
        rst_n = 1'b1;
        set_a(1'b1, 1'b0, 10'h022, 32'h0, 4'h0);
        @(negedge clk); idle();
        #1;
        n_cmp++; if (a_rvalid !== 1'b1 || a_rdata !== 32'hC0FFEE01) begin
            n_bad++; $display("FAIL rr_retain got %b/%h want 1/c0ffee01", a_rvalid, a_rdata); end
    endtask

    task automatic test_random();
        logic        pa_v, pa_w, pb_v, pb_w, pa_keep, pb_keep, sb, m_prio;
        logic [9:0]  pa_ad, pb_ad;
        logic [31:0] pa_d, pb_d, ea_d, eb_d, last_a, last_b;
        logic [3:0]  pa_s, pb_s;
        logic        exp_ar, exp_br, ea_rv, eb_rv;
        int          wa, wb, max_wait;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            pa_ad = {2'(i / 8), 8'(i % 8)};
            pa_d  = $urandom;
            set_a(1'b1, 1'b1, pa_ad, pa_d, 4'hF);
            mdl[pa_ad] = pa_d;
        end
        @(negedge clk); idle();
        last_a = 32'hC0FFEE01; last_b = 32'h33334444;
        m_prio = 1'b0; pa_keep = 1'b0; pb_keep = 1'b0;
        wa = 0; wb = 0; max_wait = 0;
        pa_v = 1'b0; pa_w = 1'b0; pa_ad = '0; pa_d = '0; pa_s = '0;
        pb_v = 1'b0; pb_w = 1'b0; pb_ad = '0; pb_d = '0; pb_s = '0;
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            if (!pa_keep) begin
                pa_v = ($urandom_range(0, 3) != 0); pa_w = 1'($urandom_range(0, 1));
                pa_ad = {2'($urandom_range(0, 3)), 8'($urandom_range(0, 7))};
                pa_d = $urandom; pa_s = 4'($urandom_range(0, 15));
            end
            if (!pb_keep) begin
                pb_v = ($urandom_range(0, 3) != 0); pb_w = 1'($urandom_range(0, 1));
                pb_ad = {2'($urandom_range(0, 3)), 8'($urandom_range(0, 7))};
                pb_d = $urandom; pb_s = 4'($urandom_range(0, 15));
            end
            set_a(pa_v, pa_w, pa_ad, pa_d, pa_s);
            set_b(pb_v, pb_w, pb_ad, pb_d, pb_s);
            #1;
            sb = (pa_ad[9:8] == pb_ad[9:8]);
            exp_ar = !(pb_v && sb && m_prio);
            exp_br = !(pa_v && sb && !m_prio);
            n_cmp++; if (a_ready !== exp_ar) begin n_bad++; $display("FAIL rnd_a_ready cyc %0d got %b want %b", c, a_ready, exp_ar); end
            n_cmp++; if (b_ready !== exp_br) begin n_bad++; $display("FAIL rnd_b_ready cyc %0d got %b want %b", c, b_ready, exp_br); end
            ea_rv = pa_v && exp_ar && !pa_w; ea_d = mdl[pa_ad];
            eb_rv = pb_v && exp_br && !pb_w; eb_d = mdl[pb_ad];
            for (int k = 0; k < 4; k++) begin
                if (pa_v && exp_ar && pa_w && pa_s[k]) mdl[pa_ad][k*8 +: 8] = pa_d[k*8 +: 8];
                if (pb_v && exp_br && pb_w && pb_s[k]) mdl[pb_ad][k*8 +: 8] = pb_d[k*8 +: 8];
            end
            if (pa_v && pb_v && sb) m_prio = !m_prio;
            pa_keep = pa_v && !exp_ar;
            pb_keep = pb_v && !exp_br;
            wa = pa_keep ? wa + 1 : 0;
            wb = pb_keep ? wb + 1 : 0;
            if (wa > max_wait) max_wait = wa;
            if (wb > max_wait) max_wait = wb;
            if (ea_rv) last_a = ea_d;
            if (eb_rv) last_b = eb_d;
            @(posedge clk); #1;
            n_cmp++; if (a_rvalid !== ea_rv || a_rdata !== last_a) begin
                n_bad++; $display("FAIL rnd_a_rd cyc %0d got %b/%h want %b/%h", c, a_rvalid, a_rdata, ea_rv, last_a); end
            n_cmp++; if (b_rvalid !== eb_rv || b_rdata !== last_b) begin
                n_bad++; $display("FAIL rnd_b_rd cyc %0d got %b/%h want %b/%h", c, b_rvalid, b_rdata, eb_rv, last_b); end
        end
        @(negedge clk); idle();
        n_cmp++; if (max_wait > 1) begin n_bad++; $display("FAIL rnd_max_wait got %0d want <=1", max_wait); end
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        test_reset();
        test_write_read();
        test_strobe();
        test_conflict();
        test_diff_banks();
        test_reset_read();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
